// File: rtl/mmio_uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
// Optional build macro: MMIO_UART_PARITY_EN (adds an even-parity bit).
package mmio_uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } tx_state_t;

    localparam logic [2:0] TXDATA_OFS = 3'd0;
    localparam logic [2:0] STATUS_OFS = 3'd4;

    localparam int ST_FULL     = 0;
    localparam int ST_EMPTY    = 1;
    localparam int ST_BUSY     = 2;
    localparam int ST_PARITY   = 3;
    localparam int ST_COUNT_LO = 8;

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// Synchronous FIFO with occupancy count; full/empty judged on pre-edge count.
// Optional build macro: none (MMIO_UART_PARITY_EN only affects the top).
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// MMIO UART transmitter: address decode, STATUS read mux and 8N1 serialiser.
// Optional build macro: MMIO_UART_PARITY_EN (inserts even-parity bit).
module mmio_uart_tx
    import mmio_uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        memwriteM,
    input  logic [31:0] dataAdrM,
    input  logic [31:0] writedataM,
    output logic        sel,
    output logic [31:0] readDataIO,
    output logic        txd,
    output logic        busy
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
`ifdef MMIO_UART_PARITY_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif

    tx_state_t     state, state_n;
    logic [BW-1:0] baud, baud_n;
    logic [2:0]    bit_idx, bit_n;
    logic [7:0]    shreg, sh_n;
    logic          txd_n;
    logic          baud_end;
    logic          push, pop;
    logic [7:0]    dout;
    logic          full, empty;
    logic [CW-1:0] fifo_count;
    logic [31:0]   status;
    logic          unused_bits;

    assign unused_bits = ^{dataAdrM[1:0], writedataM[31:8]};

    assign sel  = (dataAdrM[31:3] == BASE_ADDR[31:3]);
    assign push = memwriteM && sel && (dataAdrM[2] == TXDATA_OFS[2]);
    assign busy = (state != S_IDLE);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (writedataM[7:0]),
        .dout  (dout),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    // STATUS word assembly and read-data mux; TXDATA reads as zero.
    always_comb begin
        status                    = '0;
        status[ST_FULL]           = full;
        status[ST_EMPTY]          = empty;
        status[ST_BUSY]           = busy;
        status[ST_PARITY]         = PAR_EN;
        status[ST_COUNT_LO +: 8]  = 8'(fifo_count);
        readDataIO                = '0;
        if (sel && dataAdrM[2] == STATUS_OFS[2]) readDataIO = status;
    end

    // Transmit FSM next state, baud/bit counters and next line level.
    always_comb begin
        state_n  = state;
        baud_n   = baud;
        bit_n    = bit_idx;
        sh_n     = shreg;
        pop      = 1'b0;
        baud_end = (baud == BW'(CLKS_PER_BIT - 1));
        unique case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    sh_n    = dout;
                    state_n = S_START;
                end
            end
            S_START: if (baud_end) state_n = S_DATA;
            S_DATA: begin
                if (baud_end) begin
                    if (bit_idx == 3'd7) begin
`ifdef MMIO_UART_PARITY_EN
                        state_n = S_PARITY;
`else
                        state_n = S_STOP;
`endif
                    end else begin
                        bit_n = bit_idx + 3'd1;
                    end
                end
            end
            S_PARITY: if (baud_end) state_n = S_STOP;
            S_STOP:   if (baud_end) state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
        if (state_n != state || baud_end) baud_n = '0;
        else if (state != S_IDLE)         baud_n = baud + 1'b1;
        if (state_n != state) bit_n = '0;
        txd_n = 1'b1;
        unique case (state_n)
            S_START:  txd_n = 1'b0;
            S_DATA:   txd_n = sh_n[bit_n];
            S_PARITY: txd_n = ^sh_n;
            default:  txd_n = 1'b1;
        endcase
    end

    // FSM registers; reset aborts any frame and forces the line idle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            txd     <= 1'b1;
        end else begin
            state   <= state_n;
            baud    <= baud_n;
            bit_idx <= bit_n;
            shreg   <= sh_n;
            txd     <= txd_n;
        end
    end

endmodule
